// File: rtl/softreg_uart_initiator.sv
// -----------------------------------------------------------------------------
// softreg_uart_initiator
//
// Host-side SoftReg initiator for the pseudo-UART mailbox responder. Each byte
// on the input stream becomes one single-beat SoftReg write. The mailbox is
// polled with SoftReg reads, and every non-empty read comes back as one byte on
// the output stream. At most one request is in flight at a time.
//
// Optional feature (macro SOFTREG_INIT_TIMEOUT_EN):
//   When defined, a read that gets no response within TIMEOUT cycles of
//   RD_WAIT is abandoned and the sticky timeout_err flag is set. When
//   undefined, RD_WAIT waits forever and timeout_err is tied to 0.
//
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   in_valid/in_ready  byte stream towards the responder (in_data)
//   out_valid/out_ready byte stream from the responder (out_data)
//   req_*              SoftRegReq: one-cycle valid pulse, fields 0 when idle,
//                      req_addr fixed at MBOX_ADDR
//   resp_valid/resp_data SoftRegResp
//   timeout_err        sticky read-timeout flag
//   busy               FSM not in IDLE
// -----------------------------------------------------------------------------
module softreg_uart_initiator #(
    parameter int DATA_WIDTH      = 8,
    parameter int FIFO_DATA_WIDTH = 64,
    parameter int MBOX_ADDR       = 1234,
    parameter int EMPTY_CODE      = 110000,
    parameter int WR_GAP          = 3,
    parameter int POLL_INTERVAL   = 16,
    parameter int TIMEOUT         = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_WIDTH-1:0]      in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       req_valid,
    output logic                       req_is_write,
    output logic [31:0]                req_addr,
    output logic [FIFO_DATA_WIDTH-1:0] req_data,
    input  logic                       resp_valid,
    input  logic [FIFO_DATA_WIDTH-1:0] resp_data,
    output logic                       timeout_err,
    output logic                       busy
);

    localparam int GAP_W  = $clog2(WR_GAP + 1);
    localparam int POLL_W = $clog2(POLL_INTERVAL + 1);

    // WR_GAP >= 2 keeps at least one WR_GAP state cycle; the wait counter is
    // 8 bits wide, so TIMEOUT must fit in it.
    if (WR_GAP < 2 || TIMEOUT < 1 || TIMEOUT > 255 || DATA_WIDTH > FIFO_DATA_WIDTH)
    begin : g_bad_params
        $error("softreg_uart_initiator: illegal parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ISSUE,
        S_WR_GAP,
        S_RD_ISSUE,
        S_RD_WAIT
    } state_t;

    // rr_last encoding: 1 = last granted request was a write
    localparam logic RR_WRITE = 1'b1;
    localparam logic RR_READ  = 1'b0;

    state_t                state_q, state_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic [POLL_W-1:0]     poll_q, poll_d;
    logic                  rr_last_q, rr_last_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  wr_pend, rd_due;

`ifdef SOFTREG_INIT_TIMEOUT_EN
    logic [7:0]            wait_q, wait_d;
    logic                  tout_q, tout_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            gap_q       <= '0;
            poll_q      <= '0;
            rr_last_q   <= RR_READ;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
`ifdef SOFTREG_INIT_TIMEOUT_EN
            wait_q      <= '0;
            tout_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            poll_q      <= poll_d;
            rr_last_q   <= rr_last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
`ifdef SOFTREG_INIT_TIMEOUT_EN
            wait_q      <= wait_d;
            tout_q      <= tout_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_last_d    = rr_last_q;
        out_data_d   = out_data_q;
        // consumer handshake; a new byte can only land while out_valid_q=0
        out_valid_d  = out_valid_q & ~out_ready;
        // poll timer free-runs down to 0 in every state
        poll_d       = (poll_q != '0) ? poll_q - 1'b1 : poll_q;
        // gap counter also drains in IDLE: its final count is the IDLE
        // arbitration cycle, so a write costs exactly WR_GAP+1 cycles
        gap_d        = (gap_q != '0) ? gap_q - 1'b1 : gap_q;
        in_ready     = 1'b0;
        req_valid    = 1'b0;
        req_is_write = 1'b0;
        req_data     = '0;
`ifdef SOFTREG_INIT_TIMEOUT_EN
        wait_d       = wait_q;
        tout_d       = tout_q;
`endif

        wr_pend = in_valid;
        // holding off reads while a byte is parked is the backpressure path
        rd_due  = !out_valid_q && (poll_q == '0);

        case (state_q)
            S_IDLE: begin
                if (wr_pend && rd_due)
                    state_d = (rr_last_q == RR_WRITE) ? S_RD_ISSUE : S_WR_ISSUE;
                else if (wr_pend)
                    state_d = S_WR_ISSUE;
                else if (rd_due)
                    state_d = S_RD_ISSUE;
            end
            S_WR_ISSUE: begin
                in_ready     = 1'b1;
                req_valid    = 1'b1;
                req_is_write = 1'b1;
                req_data     = FIFO_DATA_WIDTH'(in_data);
                rr_last_d    = RR_WRITE;
                gap_d        = GAP_W'(WR_GAP);
                state_d      = S_WR_GAP;
            end
            S_WR_GAP: begin
                if (gap_q <= GAP_W'(2))
                    state_d = S_IDLE;
            end
            S_RD_ISSUE: begin
                // a resp_valid here cannot belong to this read; ignore it
                req_valid = 1'b1;
                rr_last_d = RR_READ;
`ifdef SOFTREG_INIT_TIMEOUT_EN
                wait_d    = '0;
`endif
                state_d   = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (resp_valid) begin
                    if (resp_data == FIFO_DATA_WIDTH'(EMPTY_CODE)) begin
                        poll_d = POLL_W'(POLL_INTERVAL);
                    end else begin
                        out_data_d  = resp_data[DATA_WIDTH-1:0];
                        out_valid_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
`ifdef SOFTREG_INIT_TIMEOUT_EN
                else if (wait_q == 8'(TIMEOUT)) begin
                    tout_d  = 1'b1;
                    poll_d  = POLL_W'(POLL_INTERVAL);
                    state_d = S_IDLE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign req_addr  = 32'(MBOX_ADDR);
    assign busy      = (state_q != S_IDLE);
`ifdef SOFTREG_INIT_TIMEOUT_EN
    assign timeout_err = tout_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule
